msg_buffer: RTL and testbench

- Buffers messages from the upstream message controller, whose msg_data/msg_valid/msg_error outputs drive this block directly.
- Messages are held in a show-ahead FIFO and presented on a valid/ready master interface.
- Upstream has no back-pressure, so a message arriving while the FIFO is full is dropped and counted.
- Error pulses are counted and never stored.

---
 rtl/msg_pkg.sv | 10 +
 rtl/msg_fifo_core.sv | 79 +++++++
 rtl/msg_buffer.sv | 75 +++++++
 tb/tb_msg_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message path (upstream controller and buffer).
package msg_pkg;

   localparam int DEF_MAX_MSG_BYTES = 32;
   localparam int DEF_DEPTH         = 4;
   localparam int DEF_CNT_WIDTH     = 16;

   typedef logic [8*DEF_MAX_MSG_BYTES-1:0] msg_t;

endpackage

// File: rtl/msg_fifo_core.sv
// Show-ahead FIFO: storage, pointers and occupancy. The head entry is held in
// a register so the output never depends combinationally on wr_data.
module msg_fifo_core #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;

   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      rd_next    = rd_ptr;
      count_next = count;
      if (pop) begin
         rd_next = rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
         count_next = count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_next = count - (PTR_W+1)'(1);
      end
   end

   // NOTE: storage has no reset; only pointers and occupancy decide what is
   // valid, which keeps the array a plain RAM-friendly structure.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_next;
         count  <= count_next;
         // Next head: the slot being written this cycle, else storage; hold when emptied.
         if (count_next != '0) begin
            if (push && (wr_ptr == rd_next)) begin
               rd_data <= wr_data;
            end else begin
               rd_data <= mem[rd_next];
            end
         end
      end
   end

   assign fill_level = count;
   assign full       = (count == (PTR_W+1)'(DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/msg_buffer.sv
// Buffers upstream messages in a show-ahead FIFO with a valid/ready output,
// dropping arrivals while full and counting drops and upstream errors.
module msg_buffer
   import msg_pkg::*;
#(
   parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
   parameter int DEPTH         = DEF_DEPTH,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
   input  logic                       msg_valid,
   input  logic                       msg_error,
   output logic [8*MAX_MSG_BYTES-1:0] m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       full,
   output logic                       empty,
   output logic [CNT_WIDTH-1:0]       drop_cnt,
   output logic [CNT_WIDTH-1:0]       err_cnt,
   input  logic                       clr_cnt
);

   logic full_int;
   logic empty_int;
   logic pop;
   logic push;
   logic drop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
   assign pop  = !empty_int && m_ready;
   assign push = msg_valid && !msg_error && (!full_int || pop);
   assign drop = msg_valid && !msg_error && full_int && !pop;

   msg_fifo_core #(
      .WIDTH (8*MAX_MSG_BYTES),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .wr_data    (msg_data),
      .rd_data    (m_data),
      .fill_level (fill_level),
      .full       (full_int),
      .empty      (empty_int)
   );

   assign m_valid = !empty_int;
   assign full    = full_int;
   assign empty   = empty_int;

   // Counters saturate at all-ones; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (clr_cnt) begin
            drop_cnt <= '0;
         end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
         end
         if (clr_cnt) begin
            err_cnt <= '0;
         end else if (msg_error && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_msg_buffer.sv
// Directed bench for msg_buffer: a queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_msg_buffer;
   import msg_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   msg_t          msg_data;
   logic          msg_valid;
   logic          msg_error;
   msg_t          m_data;
   logic          m_valid;
   logic          m_ready;
   logic [LW-1:0] fill_level;
   logic          full;
   logic          empty;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] err_cnt;
   logic          clr_cnt;

   int vectors;
   int miscompares;

   msg_buffer #(
      .MAX_MSG_BYTES (DEF_MAX_MSG_BYTES),
      .DEPTH         (DEPTH),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .msg_data   (msg_data),
      .msg_valid  (msg_valid),
      .msg_error  (msg_error),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .fill_level (fill_level),
      .full       (full),
      .empty      (empty),
      .drop_cnt   (drop_cnt),
      .err_cnt    (err_cnt),
      .clr_cnt    (clr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a queue of messages and plain integer counters.
   msg_t q[$];
   msg_t mdl_head;
   int   mdl_drop;
   int   mdl_err;
   bit   mdl_pop;
   bit   mdl_push;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         mdl_head = '0;
         mdl_drop = 0;
         mdl_err  = 0;
      end else begin
         mdl_pop  = (q.size() > 0) && m_ready;
         mdl_push = msg_valid && !msg_error && ((q.size() < DEPTH) || mdl_pop);
         if (clr_cnt) begin
            mdl_drop = 0;
            mdl_err  = 0;
         end else begin
            if (msg_error && mdl_err < (1 << CW) - 1) mdl_err++;
            if (msg_valid && !msg_error && !mdl_push && mdl_drop < (1 << CW) - 1) mdl_drop++;
         end
         if (mdl_pop) void'(q.pop_front());
         if (mdl_push) q.push_back(msg_data);
         if (q.size() > 0) mdl_head = q[0];
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("m_valid", m_valid, q.size() > 0);
         check("m_data", m_data, mdl_head);
         check("fill_level", fill_level, q.size());
         check("full", full, q.size() == DEPTH);
         check("empty", empty, q.size() == 0);
         check("drop_cnt", drop_cnt, mdl_drop);
         check("err_cnt", err_cnt, mdl_err);
      end
   end

   // One clock cycle of stimulus; returns just after the active edge.
   task automatic cycle(input logic v, input logic e, input msg_t d, input logic r, input logic c);
      @(negedge clk);
      #1;
      msg_valid = v;
      msg_error = e;
      msg_data  = d;
      m_ready   = r;
      clr_cnt   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   function automatic msg_t pat(input logic [7:0] b);
      return {32{b}};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      msg_t d [5];
      vectors     = 0;
      miscompares = 0;
      rst       = 1'b0;
      msg_valid = 1'b0;
      msg_error = 1'b0;
      msg_data  = '0;
      m_ready   = 1'b0;
      clr_cnt   = 1'b0;
      for (int i = 0; i < 5; i++) d[i] = pat(8'h10 + 8'(i));

      // Reset state
      #12;
      check("rst m_valid", m_valid, 1'b0);
      check("rst m_data", m_data, '0);
      check("rst empty", empty, 1'b1);
      check("rst full", full, 1'b0);
      check("rst fill", fill_level, 0);
      check("rst drop", drop_cnt, 0);
      check("rst err", err_cnt, 0);
      rst = 1'b1;

      // Single message with one-cycle latency
      cycle(1'b1, 1'b0, pat(8'hA5), 1'b0, 1'b0);
      check("single m_valid", m_valid, 1'b1);
      check("single m_data", m_data, pat(8'hA5));
      check("single fill", fill_level, 3'd1);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("single drained", m_valid, 1'b0);
      check("single empty", empty, 1'b1);
      check("single hold", m_data, pat(8'hA5));
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("ready on empty", fill_level, 3'd0);

      // Fill and drop
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, d[i], 1'b0, 1'b0);
      check("fill full", full, 1'b1);
      idle();
      check("stall hold", m_data, d[0]);
      cycle(1'b1, 1'b0, pat(8'hEE), 1'b0, 1'b0);
      check("drop cnt", drop_cnt, 4'd1);
      check("drop fill", fill_level, 3'd4);
      for (int i = 0; i < 4; i++) begin
         check("drain order", m_data, d[i]);
         cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      check("drain empty", empty, 1'b1);

      // Full with simultaneous push and pop
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("clr drop", drop_cnt, 4'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, d[i], 1'b0, 1'b0);
      cycle(1'b1, 1'b0, d[4], 1'b1, 1'b0);
      check("pp drop", drop_cnt, 4'd0);
      check("pp fill", fill_level, 3'd4);
      for (int i = 1; i < 5; i++) begin
         check("pp order", m_data, d[i]);
         cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      check("pp empty", empty, 1'b1);

      // Error handling
      cycle(1'b1, 1'b1, pat(8'h77), 1'b0, 1'b0);
      check("err no store", fill_level, 3'd0);
      check("err cnt1", err_cnt, 4'd1);
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check("err cnt2", err_cnt, 4'd2);
      check("err drop", drop_cnt, 4'd0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check("err sat", err_cnt, 4'hF);

      // Drop saturation and clear priority
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, d[i], 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, pat(8'h55), 1'b0, 1'b0);
      check("drop sat", drop_cnt, 4'hF);
      cycle(1'b1, 1'b0, pat(8'h55), 1'b0, 1'b1);
      check("clr prio drop", drop_cnt, 4'd0);
      check("clr prio err", err_cnt, 4'd0);

      // Asynchronous reset mid-stream
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, '0, 1'b0, 1'b0);
      check("pre-rst fill", fill_level, 3'd3);
      @(negedge clk);
      #1;
      msg_valid = 1'b0;
      msg_error = 1'b0;
      m_ready   = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("arst m_valid", m_valid, 1'b0);
      check("arst m_data", m_data, '0);
      check("arst fill", fill_level, 3'd0);
      check("arst drop", drop_cnt, 4'd0);
      check("arst err", err_cnt, 4'd0);
      #1;
      rst = 1'b1;
      cycle(1'b1, 1'b0, d[3], 1'b0, 1'b0);
      check("resume m_valid", m_valid, 1'b1);
      check("resume m_data", m_data, d[3]);
      check("resume fill", fill_level, 3'd1);
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
